// File: rtl/fpu_ss_commit_buffer.sv
`default_nettype none
// ============================================================================
// fpu_ss_commit_buffer
//   Holds accepted offloads in order until commit or kill, then releases
//   committed entries to the decoder and drops killed ones.
//   Payload layout: {rs2, rs1, rs0, instr_data, id, mode[1:0]}.
// Revision: 1.0
// ============================================================================
module fpu_ss_commit_buffer #(
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned ID_WIDTH = 4,
    localparam int unsigned DATA_W   = 3*32 + 32 + ID_WIDTH + 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic                empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  comm_q, comm_d;
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push, pop, push_match;

    // Status outputs come from registered state only.
    assign in_ready_o  = (count_q < CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign out_valid_o = valid_q[rd_ptr_q] & comm_q[rd_ptr_q] & ~kill_q[rd_ptr_q];
    assign out_data_o  = data_q[rd_ptr_q];

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        comm_d     = comm_q;
        kill_d     = kill_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push       = in_valid_i & in_ready_o;
        pop        = valid_q[rd_ptr_q] & comm_q[rd_ptr_q]
                     & (kill_q[rd_ptr_q] | out_ready_i);
        push_match = commit_valid_i && (in_data_i[ID_WIDTH+1:2] == commit_id_i);

        // Only the first commit/kill for an id takes effect.
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && valid_q[i] && !comm_q[i]
                && (data_q[i][ID_WIDTH+1:2] == commit_id_i)) begin
                comm_d[i] = 1'b1;
                kill_d[i] = commit_kill_i;
            end
        end

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            comm_d[rd_ptr_q]  = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            data_d[wr_ptr_q]  = in_data_i;
            valid_d[wr_ptr_q] = 1'b1;
            comm_d[wr_ptr_q]  = push_match;
            kill_d[wr_ptr_q]  = push_match & commit_kill_i;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            comm_q   <= '0;
            kill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            comm_q   <= comm_d;
            kill_q   <= kill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_commit_buffer.sv
`default_nettype none
// ============================================================================
// tb_fpu_ss_commit_buffer
//   Random offload/commit/kill traffic against an in-order queue model.
// Revision: 1.0
// ============================================================================
module tb_fpu_ss_commit_buffer;

    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int DW    = 3*32 + 32 + IDW + 2;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [DW-1:0]  in_data_i;
    logic           commit_valid_i;
    logic [IDW-1:0] commit_id_i;
    logic           commit_kill_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [DW-1:0]  out_data_o;
    logic           empty_o;

    fpu_ss_commit_buffer #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .empty_o        (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            c;
        bit            k;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IDW-1:0] id_of(input logic [DW-1:0] d);
        return d[IDW+1:2];
    endfunction

    function automatic bit id_held(input logic [IDW-1:0] id);
        foreach (q[i]) if (id_of(q[i].d) == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        bit head_rel;
        head_rel = (q.size() > 0) && q[0].c && !q[0].k;
        chk("in_ready", DW'(in_ready_o), DW'(q.size() < DEPTH));
        chk("empty", DW'(empty_o), DW'(q.size() == 0));
        chk("out_valid", DW'(out_valid_o), DW'(head_rel));
        if (q.size() > 0) chk("out_data", out_data_o, q[0].d);
    endtask

    // Reference behaviour at one rising edge, using pre-edge state.
    task automatic model_edge();
        bit   do_pop, do_push, pmatch;
        ent_t e;
        do_push = in_valid_i && (q.size() < DEPTH);
        do_pop  = (q.size() > 0) && q[0].c && (q[0].k || out_ready_i);
        if (commit_valid_i)
            foreach (q[i])
                if (!q[i].c && id_of(q[i].d) == commit_id_i) begin
                    q[i].c = 1'b1;
                    q[i].k = commit_kill_i;
                end
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            pmatch = commit_valid_i && (id_of(in_data_i) == commit_id_i);
            e.d = in_data_i;
            e.c = pmatch;
            e.k = pmatch && commit_kill_i;
            q.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        in_valid_i     = 1'b0;
        in_data_i      = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        out_ready_i    = 1'b0;
    endtask

    task automatic drive_random(input int cyc);
        logic [IDW-1:0] id;
        int             tries;
        int             ccut;
        idle_inputs();
        // Phases: long backpressure stretches and starved commits.
        ccut = ((cyc % 200) < 40) ? 10 : 55;
        out_ready_i = ((cyc % 64) < 12) ? 1'b0 : ($urandom_range(0, 99) < 75);
        id = IDW'($urandom);
        tries = 0;
        while (id_held(id) && tries < 64) begin
            id = IDW'($urandom);
            tries++;
        end
        if (!id_held(id) && $urandom_range(0, 99) < 65) begin
            in_valid_i = 1'b1;
            in_data_i  = {$urandom(), $urandom(), $urandom(), $urandom(), id, 2'($urandom)};
        end
        if ($urandom_range(0, 99) < ccut) begin
            commit_valid_i = 1'b1;
            commit_kill_i  = ($urandom_range(0, 99) < 35);
            if (in_valid_i && $urandom_range(0, 99) < 20)
                commit_id_i = id;
            else if (q.size() > 0 && $urandom_range(0, 99) < 80)
                commit_id_i = id_of(q[$urandom_range(0, q.size() - 1)].d);
            else
                commit_id_i = IDW'($urandom);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", DW'(in_ready_o), DW'(1));
        chk("rst_valid", DW'(out_valid_o), DW'(0));
        chk("rst_empty", DW'(empty_o), DW'(1));
        chk("rst_data", out_data_o, '0);
        rst_ni = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_outputs();
            if (cyc == 1500) begin
                // Asynchronous reset while entries are outstanding.
                #2 rst_ni = 1'b0;
                #1;
                chk("arst_ready", DW'(in_ready_o), DW'(1));
                chk("arst_valid", DW'(out_valid_o), DW'(0));
                chk("arst_empty", DW'(empty_o), DW'(1));
                chk("arst_data", out_data_o, '0);
                q.delete();
                idle_inputs();
                @(negedge clk);
                rst_ni = 1'b1;
                check_outputs();
            end
            drive_random(cyc);
            @(posedge clk);
            model_edge();
        end

        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
